// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar.
// Contents:
//   arb_state_e      - arbiter FSM states (ARB_IDLE, ARB_LOCKED)
//   DefaultMaxBeats  - default maximum packet length in beats
//   clog2_min1()     - ceil(log2(n)) clamped to a minimum of 1
package stream_xbar_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultMaxBeats = 256;

  // Index widths must never collapse to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker.
// Selects the first eligible request (req & ~mask) at or after start_ptr,
// searching upward and wrapping modulo NUM_REQUEST.
// Ports:
//   req       in  NUM_REQUEST  request vector
//   mask      in  NUM_REQUEST  sources excluded from this pick
//   start_ptr in  IdxW         highest-priority position
//   pick      out NUM_REQUEST  one-hot winner, zero when none
//   pick_idx  out IdxW         binary index of winner, zero when none
//   any       out 1            a winner exists
module rr_prio_pick
  import stream_xbar_pkg::*;
#(
  parameter  int unsigned NUM_REQUEST = 4,
  localparam int unsigned IdxW        = clog2_min1(NUM_REQUEST)
) (
  input  logic [NUM_REQUEST-1:0] req,
  input  logic [NUM_REQUEST-1:0] mask,
  input  logic [IdxW-1:0]        start_ptr,
  output logic [NUM_REQUEST-1:0] pick,
  output logic [IdxW-1:0]        pick_idx,
  output logic                   any
);

  localparam int N  = int'(NUM_REQUEST);
  localparam int N2 = 2 * N;

  logic [NUM_REQUEST-1:0] eligible;
  logic [N2-1:0]          dbl;

  assign eligible = req & ~mask;
  // Upper copy supplies the wrapped-around candidates below start_ptr.
  assign dbl      = {eligible, eligible};

  always_comb begin
    any      = 1'b0;
    pick_idx = '0;
    // Downward scan: the lowest qualifying position is assigned last and wins.
    for (int i = N2 - 1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(start_ptr))) begin
        any = 1'b1;
        if (i >= N) begin
          pick_idx = IdxW'(i - N);
        end else begin
          pick_idx = IdxW'(i);
        end
      end
    end
  end

  assign pick = any ? (NUM_REQUEST'(1) << pick_idx) : '0;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter for one crossbar output port.
// A grant is held for a whole packet and released on the granted source's
// last-beat handshake; priority then rotates past the winner, and a waiting
// source is granted in the same cycle (no idle bubble).
// Optional feature macro: STREAM_RR_ARB_TIMEOUT_EN (adds timeout_o and a
// forced release after MAX_BEATS beats without last).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   request_i       per-source tvalid
//   s_last_i        per-source tlast
//   m_ready_i       downstream tready
//   grant_o         one-hot registered grant, zero when idle
//   grant_idx_o     binary index of granted source
//   grant_valid_o   arbiter locked to a source
//   pkt_done_o      pulse on the granted source's last beat
//   beat_cnt_o      beats transferred in the current packet
//   timeout_o       pulse on a forced release (macro only)
module stream_rr_arbiter
  import stream_xbar_pkg::*;
#(
  parameter  int unsigned NUM_REQUEST = 4,
  parameter  int unsigned MAX_BEATS   = DefaultMaxBeats,
  localparam int unsigned IDX_W       = clog2_min1(NUM_REQUEST),
  localparam int unsigned BEAT_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQUEST-1:0] request_i,
  input  logic [NUM_REQUEST-1:0] s_last_i,
  input  logic                   m_ready_i,
  output logic [NUM_REQUEST-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   grant_valid_o,
  output logic                   pkt_done_o,
  output logic [BEAT_W-1:0]      beat_cnt_o
`ifdef STREAM_RR_ARB_TIMEOUT_EN
  ,
  output logic                   timeout_o
`endif
);

  arb_state_e             state_q, state_d;
  logic [NUM_REQUEST-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [BEAT_W-1:0]      cnt_q, cnt_d;

  logic                   locked;
  logic                   beat;
  logic                   last_beat;
  logic                   timeout_hit;
  logic                   release_ev;
  logic [IDX_W-1:0]       next_ptr;

  logic [NUM_REQUEST-1:0] pick_mask;
  logic [IDX_W-1:0]       pick_start;
  logic [NUM_REQUEST-1:0] pick;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  assign locked    = (state_q == ARB_LOCKED);
  assign beat      = locked & request_i[idx_q] & m_ready_i;
  assign last_beat = beat & s_last_i[idx_q];

`ifdef STREAM_RR_ARB_TIMEOUT_EN
  assign timeout_hit = beat & ~s_last_i[idx_q] & (cnt_q == BEAT_W'(MAX_BEATS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_ev = last_beat | timeout_hit;

  // Rotate past the current winner; explicit compare keeps non-power-of-two
  // counts correct without a modulo.
  assign next_ptr = (idx_q == IDX_W'(NUM_REQUEST - 1)) ? '0 : idx_q + 1'b1;

  // One picker serves both cases: IDLE picks from the stored pointer, the
  // handoff pick excludes the releasing source and starts from next_ptr.
  assign pick_mask  = locked ? grant_q : '0;
  assign pick_start = locked ? next_ptr : ptr_q;

  rr_prio_pick #(
    .NUM_REQUEST(NUM_REQUEST)
  ) u_pick (
    .req      (request_i),
    .mask     (pick_mask),
    .start_ptr(pick_start),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_LOCKED;
          grant_d = pick;
          idx_d   = pick_idx;
        end
      end
      ARB_LOCKED: begin
        if (release_ev) begin
          ptr_d = next_ptr;
          cnt_d = '0;
          if (pick_any) begin
            grant_d = pick;
            idx_d   = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            idx_d   = '0;
          end
        end else if (beat && (cnt_q != BEAT_W'(MAX_BEATS))) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = idx_q;
  assign grant_valid_o = locked;
  assign beat_cnt_o    = cnt_q;
  // A release coinciding with reset is abandoned, so no pulse escapes.
  assign pkt_done_o    = last_beat & ~rst;
`ifdef STREAM_RR_ARB_TIMEOUT_EN
  assign timeout_o     = timeout_hit & ~rst;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: a 4-source instance (MAX_BEATS=4)
// and a 3-source instance (MAX_BEATS=256) driven with directed vectors.
module tb_stream_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] req_a = '0, last_a = '0, grant_a;
  logic       rdy_a = 1'b0, valid_a, done_a, tmo_a;
  logic [1:0] idx_a;
  logic [2:0] cnt_a;

  logic [2:0] req_b = '0, last_b = '0, grant_b;
  logic       rdy_b = 1'b0, valid_b, done_b, tmo_b;
  logic [1:0] idx_b;
  logic [8:0] cnt_b;

  stream_rr_arbiter #(.NUM_REQUEST(4), .MAX_BEATS(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .request_i    (req_a),
    .s_last_i     (last_a),
    .m_ready_i    (rdy_a),
    .grant_o      (grant_a),
    .grant_idx_o  (idx_a),
    .grant_valid_o(valid_a),
    .pkt_done_o   (done_a),
    .beat_cnt_o   (cnt_a)
`ifdef STREAM_RR_ARB_TIMEOUT_EN
    ,
    .timeout_o    (tmo_a)
`endif
  );

  stream_rr_arbiter #(.NUM_REQUEST(3), .MAX_BEATS(256)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .request_i    (req_b),
    .s_last_i     (last_b),
    .m_ready_i    (rdy_b),
    .grant_o      (grant_b),
    .grant_idx_o  (idx_b),
    .grant_valid_o(valid_b),
    .pkt_done_o   (done_b),
    .beat_cnt_o   (cnt_b)
`ifdef STREAM_RR_ARB_TIMEOUT_EN
    ,
    .timeout_o    (tmo_b)
`endif
  );

`ifndef STREAM_RR_ARB_TIMEOUT_EN
  assign tmo_a = 1'b0;
  assign tmo_b = 1'b0;
`endif

  typedef struct {
    bit         sel;  // 0: dut_a, 1: dut_b
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
    logic       done;
    logic [8:0] cnt;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [17:0] act, want;
      e = sb.pop_front();
      if (!e.sel) act = {grant_a, idx_a, valid_a, done_a, {6'b0, cnt_a}, tmo_a};
      else        act = {1'b0, grant_b, idx_b, valid_b, done_b, cnt_b, tmo_b};
      want = {e.grant, e.idx, e.valid, e.done, e.cnt, e.tmo};
      total++;
      if (act !== want) begin
        bad++;
        $display("FAIL %s: got grant=%b idx=%0d valid=%b done=%b cnt=%0d tmo=%b, want grant=%b idx=%0d valid=%b done=%b cnt=%0d tmo=%b",
                 e.name, act[17:14], act[13:12], act[11], act[10], act[9:1], act[0],
                 want[17:14], want[13:12], want[11], want[10], want[9:1], want[0]);
      end
    end
  end

  task automatic push(input bit sel, input string nm, input logic [3:0] g, input logic [1:0] ix,
                      input logic v, input logic d, input int c, input logic t);
    exp_t e;
    e.sel = sel; e.grant = g; e.idx = ix; e.valid = v; e.done = d;
    e.cnt = 9'(c); e.tmo = t; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step_a(input string nm, input bit r, input logic [3:0] rq, input logic [3:0] ls,
                        input bit rd, input logic [3:0] g, input logic [1:0] ix, input bit v,
                        input bit d, input int c, input bit t);
    @(posedge clk);
    #1;
    rst = r; req_a = rq; last_a = ls; rdy_a = rd;
    push(1'b0, nm, g, ix, v, d, c, t);
  endtask

  task automatic step_b(input string nm, input logic [2:0] rq, input logic [2:0] ls,
                        input logic [2:0] g, input logic [1:0] ix, input bit v, input bit d);
    @(posedge clk);
    #1;
    rst = 1'b0; req_b = rq; last_b = ls; rdy_b = 1'b1;
    push(1'b1, nm, {1'b0, g}, ix, v, d, 0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step_a("rst_state", 0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Grant one cycle after request, two-beat packet, zero-bubble handoff.
    step_a("t1_idle",    0, 4'b1010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("t1_grant",   0, 4'b1010, 4'b0000, 1, 4'b0010, 1, 1, 0, 0, 0);
    step_a("t1_last",    0, 4'b1010, 4'b0010, 1, 4'b0010, 1, 1, 1, 1, 0);
    step_a("t1_handoff", 0, 4'b1000, 4'b1000, 1, 4'b1000, 3, 1, 1, 0, 0);
    step_a("t1_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Last held without ready: no release, count frozen.
    step_a("st_idle",    0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("st_beat",    0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      step_a("st_stall", 0, 4'b0001, 4'b0001, 0, 4'b0001, 0, 1, 0, 1, 0);
    step_a("st_rel",     0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 1, 0);
    step_a("st_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Granted source 2 drops request mid-packet while source 0 waits.
    step_a("dr_idle",    0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("dr_beat",    0, 4'b0101, 4'b0000, 1, 4'b0100, 2, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++)
      step_a("dr_drop",  0, 4'b0001, 4'b0000, 1, 4'b0100, 2, 1, 0, 1, 0);
    step_a("dr_last",    0, 4'b0101, 4'b0100, 1, 4'b0100, 2, 1, 1, 1, 0);
    step_a("dr_hand",    0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 0, 0);
    step_a("dr_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Long packet on source 0 with source 3 waiting (MAX_BEATS=4).
    step_a("lp_idle",    0, 4'b0001, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("lp_b1",      0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 0, 0);
    step_a("lp_b2",      0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 1, 0);
    step_a("lp_b3",      0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 2, 0);
`ifdef STREAM_RR_ARB_TIMEOUT_EN
    step_a("to_b4",      0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 3, 1);
    step_a("to_hand",    0, 4'b1000, 4'b1000, 1, 4'b1000, 3, 1, 1, 0, 0);
`else
    step_a("sat_b4",     0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 3, 0);
    step_a("sat_b5",     0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1, 0, 4, 0);
    step_a("sat_b6",     0, 4'b1001, 4'b0001, 1, 4'b0001, 0, 1, 1, 4, 0);
    step_a("sat_hand",   0, 4'b1000, 4'b1000, 1, 4'b1000, 3, 1, 1, 0, 0);
`endif
    step_a("lp_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Single requester: one idle cycle between back-to-back packets.
    step_a("ss_idle",    0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("ss_p1",      0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 0, 0);
    step_a("ss_gap",     0, 4'b0010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("ss_p2",      0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 0, 0);
    step_a("ss_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Reset mid-packet, last beat suppressed; pointer back to 0 (pick 1, not 3).
    step_a("rs_idle",    0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("rs_beat",    0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 0, 0, 0);
    step_a("rs_assert",  1, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 0, 1, 0);
    step_a("rs_after",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("rs_ptr_req", 0, 4'b1010, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    step_a("rs_ptr",     0, 4'b0000, 4'b0000, 1, 4'b0010, 1, 1, 0, 0, 0);
    step_a("rs_rel",     0, 4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1, 0, 0);
    step_a("rs_idle2",   0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // Three sources, all requesting, single-beat packets: 0,1,2,0,1,2.
    step_b("b_idle",  3'b111, 3'b000, 3'b000, 0, 0, 0);
    step_b("b_g0",    3'b111, 3'b111, 3'b001, 0, 1, 1);
    step_b("b_g1",    3'b111, 3'b111, 3'b010, 1, 1, 1);
    step_b("b_g2",    3'b111, 3'b111, 3'b100, 2, 1, 1);
    step_b("b_g0w",   3'b111, 3'b111, 3'b001, 0, 1, 1);
    step_b("b_g1w",   3'b111, 3'b111, 3'b010, 1, 1, 1);
    step_b("b_g2w",   3'b111, 3'b111, 3'b100, 2, 1, 1);
    step_b("b_noreq", 3'b000, 3'b000, 3'b001, 0, 1, 0);
    step_b("b_last",  3'b001, 3'b001, 3'b001, 0, 1, 1);
    step_b("b_idle2", 3'b000, 3'b000, 3'b000, 0, 0, 0);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Packet-locked round-robin arbiter for one crossbar output port; generalised successor of the 4-input arbiter.
- Any NUM_REQUEST ≥ 2, including non-power-of-two.
- Grant is held for a whole packet, released only on the granted source's last-beat handshake, then priority rotates past the winner.
- Drives the output mux select and ready steering in the stream crossbar.

Parameters:
- NUM_REQUEST, 4, number of input streams competing for this output (≥2).
- MAX_BEATS, 256, max packet length in beats; sizes the beat counter and the timeout limit.
- IDX_W, $clog2(NUM_REQUEST) (localparam, min 1), width of source index.
- BEAT_W, $clog2(MAX_BEATS+1) (localparam), beat counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- request_i  input  NUM_REQUEST  per-source tvalid.
- s_last_i  input  NUM_REQUEST  per-source tlast.
- m_ready_i  input  1  downstream tready of this output.
- grant_o  output  NUM_REQUEST  one-hot registered grant; all-zero when idle.
- grant_idx_o  output  IDX_W  binary index of the granted source; valid when grant_valid_o=1.
- grant_valid_o  output  1  arbiter locked to a source.
- pkt_done_o  output  1  one-cycle pulse on the granted source's last beat.
- beat_cnt_o  output  BEAT_W  beats transferred in the current packet.

Behaviour:
- Reset values: grant_o=0, grant_idx_o=0, grant_valid_o=0, pkt_done_o=0, beat_cnt_o=0. prio_ptr=0. State IDLE.
- Beat definition: beat = grant_valid_o & request_i[grant_idx_o] & m_ready_i.
- Priority pick (combinational): first set request at or after prio_ptr, searching upward, wrapping modulo NUM_REQUEST.
- IDLE:
  - If any request_i bit is set, register the pick into grant_o/grant_idx_o, set grant_valid_o, go to LOCKED.
  - Grant is visible 1 cycle after request. No beat is accepted in IDLE.
- LOCKED:
  - On a beat, beat_cnt_o increments, saturating at MAX_BEATS.
  - Deasserting request_i mid-packet does not release the grant.
  - Requests from other sources are ignored until release.
- Release (beat & s_last_i[grant_idx_o]):
  - pkt_done_o=1 for that cycle.
  - Next cycle: beat_cnt_o=0.
  - prio_ptr <= grant_idx_o+1, wrapping to 0 when it equals NUM_REQUEST-1. No modulo operator; the comparison must be correct for non-power-of-two counts.
- Zero-bubble handoff:
  - In the release cycle, re-arbitrate among request_i with the current source masked out, searching from the new prio_ptr.
  - If a winner exists, stay LOCKED with the new grant next cycle. Otherwise go to IDLE.
  - The current source's own next packet waits at least one cycle and gets lowest priority.
- A single-beat packet (last on the first beat) is legal: one beat, then release.
- s_last_i on non-granted sources, or without m_ready_i, has no effect.
- rst mid-packet: all state returns to reset values next edge. No pulse is generated.
- grant_o is always one-hot or zero. grant_o == (grant_valid_o << grant_idx_o).

Optional Feature:
- Macro: STREAM_RR_ARB_TIMEOUT_EN.
- Defined:
  - Adds output timeout_o (1 bit).
  - When a beat occurs with beat_cnt_o == MAX_BEATS-1 and no last, the arbiter force-releases as if it were a last beat.
  - Same rotation and handoff as a normal release; timeout_o=1 for that cycle, pkt_done_o=0.
- Undefined:
  - No timeout_o port. Grant is held until the real last beat.
  - beat_cnt_o saturates at MAX_BEATS.

Decomposition:
- stream_xbar_pkg holds:
  - arb_state_e enum {ARB_IDLE, ARB_LOCKED};
  - the clog2-with-min-1 helper function;
  - default MAX_BEATS constant.
- One sub-module, rr_prio_pick: combinational, parameter NUM_REQUEST.
  - Inputs: req, mask, start_ptr.
  - Outputs: one-hot pick, pick_idx, any.
  - Implemented as a double-width request vector with a fixed-priority scan.
  - Instantiated once and reused for both the IDLE pick and the handoff pick.

Test Plan:
- NUM_REQUEST=4, request_i=4'b1010 from reset → grant_o=4'b0010, idx=1 one cycle later. Two-beat packet done → next cycle grant_o=4'b1000, no idle cycle.
- NUM_REQUEST=3, all requesting continuously, 1-beat packets → grant index sequence 0,1,2,0,1,2; prio_ptr wraps 2→0.
- Granted source 2 drops request_i mid-packet while source 0 requests → grant stays on 2 until its last beat. pkt_done_o pulses exactly once.
- m_ready_i=0 while last is asserted for 3 cycles → no release, beat_cnt_o frozen. Release on the first cycle with ready=1.
- Only source 1 requests, back-to-back packets → one IDLE cycle between packets, regrant to 1.
- TIMEOUT_EN with MAX_BEATS=4, 6-beat packet on source 0, source 3 waiting → force-release after beat 4, timeout_o pulse, grant_o=4'b1000 next cycle. Separately, rst asserted mid-packet → all outputs 0 next cycle.
